// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue: a DEPTH-entry circular buffer of {pc, instruction} pairs
// between fetch and decode, with a one-cycle branch flush and a saturating squash counter.
module if_id_fetch_queue #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] BUBBLE_INSTR = '0,
    parameter int              CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic [XLEN-1:0]          fetch_instr,
    output logic                     fetch_ready,
    output logic                     dec_valid,
    output logic [XLEN-1:0]          dec_pc,
    output logic [XLEN-1:0]          dec_instr,
    input  logic                     dec_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         flushed_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
    localparam logic [OCC_W-1:0] DEPTH_CNT = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] flushedCnt_q, flushedCnt_d;
    logic [XLEN-1:0]  pcMem_q    [DEPTH];
    logic [XLEN-1:0]  instrMem_q [DEPTH];
    logic             push;
    logic             pop;
    logic [SUM_W-1:0] flushSum;

    assign full        = (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign fetch_ready = !full;
    assign dec_valid   = !empty;
    assign push        = fetch_valid & fetch_ready;
    assign pop         = dec_valid & dec_ready;
    assign count       = count_q;
    assign flushed_cnt = flushedCnt_q;

    // Head is masked while empty so stale or uninitialised storage never reaches decode.
    assign dec_pc    = dec_valid ? pcMem_q[rdPtr_q]    : '0;
    assign dec_instr = dec_valid ? instrMem_q[rdPtr_q] : BUBBLE_INSTR;

    always_comb begin
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        count_d      = count_q;
        flushedCnt_d = flushedCnt_q;
        flushSum     = SUM_W'(flushedCnt_q) + SUM_W'(count_q);
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            if (flushSum > SUM_W'(CNT_MAX)) begin
                flushedCnt_d = CNT_MAX;
            end else begin
                flushedCnt_d = flushSum[CNT_W-1:0];
            end
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            flushedCnt_q <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            flushedCnt_q <= flushedCnt_d;
        end
    end

    // Storage has no reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            pcMem_q[wrPtr_q]    <= fetch_pc;
            instrMem_q[wrPtr_q] <= fetch_instr;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Randomised self-checking bench for if_id_fetch_queue against a queue-based reference model;
// a second instance with a 2-bit squash counter exercises saturation.
module tb_if_id_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            fetchValid;
    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] fetchInstr;
    logic            decReady;
    logic            flush;

    logic            fetchReady, decValid, full, empty;
    logic [XLEN-1:0] decPc, decInstr;
    logic [2:0]      count;
    logic [15:0]     flushedCnt;

    logic            fetchReadyS, decValidS, fullS, emptyS;
    logic [XLEN-1:0] decPcS, decInstrS;
    logic [2:0]      countS;
    logic [1:0]      flushedCntS;

    entry_t modelQ[$];
    longint flushTotal;
    int     vectors;
    int     miscompares;

    always #5 clk = ~clk;

    if_id_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .BUBBLE_INSTR(32'h0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetchValid), .fetch_pc(fetchPc),
        .fetch_instr(fetchInstr), .fetch_ready(fetchReady), .dec_valid(decValid),
        .dec_pc(decPc), .dec_instr(decInstr), .dec_ready(decReady), .flush(flush),
        .count(count), .full(full), .empty(empty), .flushed_cnt(flushedCnt)
    );

    if_id_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .BUBBLE_INSTR(32'h0), .CNT_W(2)) dutSmall (
        .clk(clk), .reset(reset), .fetch_valid(fetchValid), .fetch_pc(fetchPc),
        .fetch_instr(fetchInstr), .fetch_ready(fetchReadyS), .dec_valid(decValidS),
        .dec_pc(decPcS), .dec_instr(decInstrS), .dec_ready(decReady), .flush(flush),
        .count(countS), .full(fullS), .empty(emptyS), .flushed_cnt(flushedCntS)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: one clock edge worth of queue behaviour from the applied inputs.
    task automatic updateModel();
        bit canPush;
        bit canPop;
        if (reset) begin
            modelQ.delete();
            flushTotal = 0;
        end else if (flush) begin
            flushTotal += modelQ.size();
            modelQ.delete();
        end else begin
            canPush = fetchValid && (modelQ.size() < DEPTH);
            canPop  = decReady && (modelQ.size() > 0);
            if (canPop) void'(modelQ.pop_front());
            if (canPush) modelQ.push_back('{pc: fetchPc, instr: fetchInstr});
        end
    endtask

    task automatic checkAll();
        int     n;
        longint bigExp;
        longint smallExp;
        n        = modelQ.size();
        bigExp   = (flushTotal > 65535) ? 65535 : flushTotal;
        smallExp = (flushTotal > 3) ? 3 : flushTotal;
        checkOutput("count",       64'(count),      64'(n));
        checkOutput("full",        64'(full),       64'(n == DEPTH));
        checkOutput("empty",       64'(empty),      64'(n == 0));
        checkOutput("fetch_ready", 64'(fetchReady), 64'(n != DEPTH));
        checkOutput("dec_valid",   64'(decValid),   64'(n != 0));
        checkOutput("dec_pc",      64'(decPc),      (n != 0) ? 64'(modelQ[0].pc)    : 64'h0);
        checkOutput("dec_instr",   64'(decInstr),   (n != 0) ? 64'(modelQ[0].instr) : 64'h0);
        checkOutput("flushed_cnt", 64'(flushedCnt), 64'(bigExp));
        checkOutput("small_count", 64'(countS),     64'(n));
        checkOutput("small_pc",    64'(decPcS),     (n != 0) ? 64'(modelQ[0].pc) : 64'h0);
        checkOutput("small_flushed_cnt", 64'(flushedCntS), 64'(smallExp));
    endtask

    task automatic applyStimulus(input logic rst, input logic fv, input logic [XLEN-1:0] pc,
                                 input logic [XLEN-1:0] instr, input logic dr, input logic fl);
        reset      = rst;
        fetchValid = fv;
        fetchPc    = pc;
        fetchInstr = instr;
        decReady   = dr;
        flush      = fl;
        @(posedge clk);
        updateModel();
        #1;
        checkAll();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        flushTotal  = 0;
        reset = 1'b1; fetchValid = 1'b0; fetchPc = '0; fetchInstr = '0; decReady = 1'b0; flush = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h40, 32'h13, 1, 1);

        // First push appears one cycle later.
        applyStimulus(0, 1, 32'h0, 32'h00500093, 0, 0);
        checkOutput("t1_instr", 64'(decInstr), 64'h00500093);

        // Fill to full, try a fifth push, then drain in order.
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'(i * 4), 32'h1000 + 32'(i), 0, 0);
        applyStimulus(0, 1, 32'h10, 32'hDEAD, 0, 0);
        checkOutput("t2_full", 64'(full), 64'h1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_order", 64'(decPc), 64'(i * 4));
            applyStimulus(0, 0, 0, 0, 1, 0);
        end

        // Simultaneous push and pop across pointer wrap.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h0, 32'hA0, 0, 0);
        applyStimulus(0, 1, 32'h4, 32'hA1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, 32'(8 + 4 * k), 32'hA2 + 32'(k), 1, 0);
            checkOutput("t3_count", 64'(count), 64'h2);
        end

        // Flush with a concurrent fetch, then repeat to saturate the small counter.
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'(i * 4), 32'hB0 + 32'(i), 0, 0);
            applyStimulus(0, 1, 32'h100, 32'hBEEF, 1, 1);
            checkOutput("t4_flushed_cnt", 64'(flushedCnt), 64'(3 * (r + 1)));
            checkOutput("t5_small_sat", 64'(flushedCntS), 64'h3);
        end

        // Reset wins over flush.
        applyStimulus(0, 1, 32'h0, 32'hC0, 0, 0);
        applyStimulus(0, 1, 32'h4, 32'hC1, 0, 0);
        applyStimulus(1, 1, 32'h8, 32'hC2, 1, 1);
        checkOutput("t6_flushed_cnt", 64'(flushedCnt), 64'h0);

        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(9) < 7), $urandom, $urandom,
                          ($urandom_range(9) < 5), ($urandom_range(11) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
